// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared state encoding and default widths for the APB requester
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - ACCESS stall counter with limit compare
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Restart on entry to ACCESS, advance once per stalled ACCESS cycle
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The stalled cycle that would bring the count to LIMIT is the abort cycle
    assign expired = enable && (count_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding APB requester; optional stall abort via APB_MASTER_TIMEOUT_EN
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
    logic timer_clear;
    logic timer_en;

    assign timer_clear = (state_q == SETUP);
    assign timer_en    = (state_q == ACCESS) && !PREADY;

    apb_wait_timer #(
        .LIMIT (TIMEOUT)
    ) u_wait_timer (
        .clk     (PCLK),
        .rst     (PRESET),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;

    // TIMEOUT has no effect without the stall timer
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    // Next-state, command acceptance and response capture
    always_comb begin
        state_d       = state_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        cmd_ready     = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    // Completion; a waiting command chains straight into SETUP
                    cmd_ready   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
                    state_d     = cmd_valid ? SETUP : IDLE;
                end else if (timeout_hit) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmd_valid && cmd_ready) begin
            paddr_d  = cmd_addr;
            pwrite_d = cmd_write;
            if (cmd_write) begin
                pwdata_d = cmd_wdata;
            end
        end

        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    // State, APB drive and response registers
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - directed self-checking bench for apb_master
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    // ctl = {PSEL, PENABLE, cmd_ready, rsp_valid}
    localparam logic [3:0] WR_CTL  [0:4] = '{4'b0010, 4'b1000, 4'b1110, 4'b0011, 4'b0010};
    localparam logic [3:0] RD_CTL  [0:5] = '{4'b0010, 4'b1000, 4'b1100, 4'b1100, 4'b1110, 4'b0011};
    localparam logic [3:0] B2B_CTL [0:8] = '{4'b0010, 4'b1000, 4'b1110, 4'b1001, 4'b1110,
                                             4'b1001, 4'b1110, 4'b0011, 4'b0010};
    localparam int          B2B_IDX  [0:8] = '{0, 1, 1, 2, 2, 3, 3, 3, 3};
    localparam logic [31:0] B2B_ADDR [0:2] = '{32'h10, 32'h14, 32'h18};
    localparam logic [31:0] B2B_DATA [0:2] = '{32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
    localparam logic [31:0] B2B_PADDR[0:8] = '{32'h08, 32'h10, 32'h10, 32'h14, 32'h14,
                                               32'h18, 32'h18, 32'h18, 32'h18};
    localparam logic [3:0] ERR_CTL [0:3] = '{4'b0010, 4'b1000, 4'b1110, 4'b0011};
    localparam logic [3:0] RST_CTL [0:8] = '{4'b0010, 4'b1000, 4'b1100, 4'b1100, 4'b0010,
                                             4'b0010, 4'b1000, 4'b1110, 4'b0011};
    localparam logic [3:0] TO_CTL  [0:12] = '{4'b0010, 4'b1000, 4'b1100, 4'b1100, 4'b1100,
                                              4'b1100, 4'b0011, 4'b1000, 4'b1100, 4'b1100,
                                              4'b1100, 4'b1110, 4'b0011};

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int vectors     = 0;
    int miscompares = 0;

    wire [3:0] ctl = {PSEL, PENABLE, cmd_ready, rsp_valid};

    apb_master #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic cyc;
        @(posedge PCLK);
        #1;
    endtask

    task automatic test_reset;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (3) cyc();
        PRESET = 1'b0;
        #1;
        vectors++;
        if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b expected 000000",
                     {PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout});
        end
        vectors++;
        if ({PADDR, PWDATA, rsp_rdata} !== 96'h0) begin
            miscompares++;
            $display("FAIL reset_data got %h expected 0", {PADDR, PWDATA, rsp_rdata});
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready got %b expected 1", cmd_ready);
        end
        cyc();
    endtask

    task automatic test_write_zero_wait;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 0);
            cmd_write = 1'b1;
            cmd_addr  = 32'h04;
            cmd_wdata = 32'hDEAD_BEEF;
            #1;
            vectors++;
            if (ctl !== WR_CTL[i]) begin
                miscompares++;
                $display("FAIL wr_ctl[%0d] got %b expected %b", i, ctl, WR_CTL[i]);
            end
            if (i == 1 || i == 2) begin
                vectors++;
                if ({PWRITE, PADDR, PWDATA} !== {1'b1, 32'h04, 32'hDEAD_BEEF}) begin
                    miscompares++;
                    $display("FAIL wr_bus[%0d] got %h expected 1_00000004_deadbeef", i,
                             {PWRITE, PADDR, PWDATA});
                end
            end
            if (i == 3) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== 34'h0) begin
                    miscompares++;
                    $display("FAIL wr_rsp got %h expected 0", {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            cyc();
        end
    endtask

    task automatic test_read_wait_states;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = (i == 0);
            cmd_write = 1'b0;
            cmd_addr  = 32'h08;
            cmd_wdata = 32'h5555_5555;
            PREADY    = (i == 4);
            PRDATA    = PREADY ? 32'h1234_5678 : 32'hBAD0_BAD0;
            PSLVERR   = (i >= 1 && i <= 3);
            #1;
            vectors++;
            if (ctl !== RD_CTL[i]) begin
                miscompares++;
                $display("FAIL rd_ctl[%0d] got %b expected %b", i, ctl, RD_CTL[i]);
            end
            if (i >= 1 && i <= 4) begin
                vectors++;
                if ({PWRITE, PADDR, PWDATA} !== {1'b0, 32'h08, 32'hDEAD_BEEF}) begin
                    miscompares++;
                    $display("FAIL rd_bus[%0d] got %h expected 0_00000008_deadbeef", i,
                             {PWRITE, PADDR, PWDATA});
                end
            end
            if (i == 5) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 32'h1234_5678}) begin
                    miscompares++;
                    $display("FAIL rd_rsp got %h expected 0_12345678",
                             {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            cyc();
        end
        PSLVERR = 1'b0;
    endtask

    task automatic test_back_to_back;
        PREADY  = 1'b1;
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            if (B2B_IDX[i] < 3) begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_addr  = B2B_ADDR[B2B_IDX[i]];
                cmd_wdata = B2B_DATA[B2B_IDX[i]];
            end else begin
                cmd_valid = 1'b0;
            end
            #1;
            vectors++;
            if (ctl !== B2B_CTL[i]) begin
                miscompares++;
                $display("FAIL b2b_ctl[%0d] got %b expected %b", i, ctl, B2B_CTL[i]);
            end
            vectors++;
            if (PADDR !== B2B_PADDR[i]) begin
                miscompares++;
                $display("FAIL b2b_paddr[%0d] got %h expected %h", i, PADDR, B2B_PADDR[i]);
            end
            if (i >= 1 && i <= 6) begin
                vectors++;
                if (PWDATA !== B2B_DATA[(i - 1) / 2]) begin
                    miscompares++;
                    $display("FAIL b2b_pwdata[%0d] got %h expected %h", i, PWDATA,
                             B2B_DATA[(i - 1) / 2]);
                end
            end
            if (i == 3 || i == 5 || i == 7) begin
                vectors++;
                if ({rsp_err, rsp_rdata} !== 33'h0) begin
                    miscompares++;
                    $display("FAIL b2b_rsp[%0d] got %h expected 0", i, {rsp_err, rsp_rdata});
                end
            end
            cyc();
        end
    endtask

    task automatic test_slave_error;
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'hCAFE_F00D;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 4; i++) begin
                cmd_valid = (i == 0);
                cmd_write = (t == 0);
                cmd_addr  = (t == 0) ? 32'h40 : 32'h44;
                cmd_wdata = 32'h55AA_55AA;
                #1;
                vectors++;
                if (ctl !== ERR_CTL[i]) begin
                    miscompares++;
                    $display("FAIL err_ctl[%0d.%0d] got %b expected %b", t, i, ctl, ERR_CTL[i]);
                end
                if (i == 3) begin
                    vectors++;
                    if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b10, 32'h0}) begin
                        miscompares++;
                        $display("FAIL err_rsp[%0d] got %h expected 2_00000000", t,
                                 {rsp_err, rsp_timeout, rsp_rdata});
                    end
                end
                cyc();
            end
        end
        PSLVERR = 1'b0;
    endtask

    task automatic test_reset_mid_transfer;
        PSLVERR = 1'b0;
        PRDATA  = 32'h0BAD_F00D;
        for (int i = 0; i < 9; i++) begin
            PRESET    = (i == 3);
            PREADY    = (i >= 4);
            cmd_valid = (i == 0 || i == 5);
            cmd_write = (i == 0);
            cmd_addr  = (i == 0) ? 32'h80 : 32'h0C;
            cmd_wdata = 32'h1111_2222;
            #1;
            vectors++;
            if (ctl !== RST_CTL[i]) begin
                miscompares++;
                $display("FAIL rst_ctl[%0d] got %b expected %b", i, ctl, RST_CTL[i]);
            end
            if (i == 4) begin
                vectors++;
                if ({PADDR, PWDATA} !== 64'h0) begin
                    miscompares++;
                    $display("FAIL rst_bus got %h expected 0", {PADDR, PWDATA});
                end
            end
            if (i == 8) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 32'h0BAD_F00D}) begin
                    miscompares++;
                    $display("FAIL rst_rsp got %h expected 0_0badf00d",
                             {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            cyc();
        end
        PRESET = 1'b0;
    endtask

`ifdef APB_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        PSLVERR = 1'b0;
        PRDATA  = 32'h7777_8888;
        for (int i = 0; i < 13; i++) begin
            cmd_valid = (i == 0 || i == 6);
            cmd_write = 1'b0;
            cmd_addr  = (i == 0) ? 32'h20 : 32'h24;
            PREADY    = (i == 11);
            #1;
            vectors++;
            if (ctl !== TO_CTL[i]) begin
                miscompares++;
                $display("FAIL to_ctl[%0d] got %b expected %b", i, ctl, TO_CTL[i]);
            end
            if (i == 6) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b11, 32'h0}) begin
                    miscompares++;
                    $display("FAIL to_abort got %h expected 3_00000000",
                             {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            if (i == 12) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 32'h7777_8888}) begin
                    miscompares++;
                    $display("FAIL to_limit_ready got %h expected 0_77778888",
                             {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            cyc();
        end
    endtask
`else
    task automatic test_no_timeout;
        PSLVERR = 1'b0;
        PRDATA  = 32'h2468_ACE0;
        for (int i = 0; i < 24; i++) begin
            cmd_valid = (i == 0);
            cmd_write = 1'b0;
            cmd_addr  = 32'h28;
            PREADY    = (i == 22);
            #1;
            vectors++;
            if (ctl !== ((i == 0) ? 4'b0010 : (i == 1) ? 4'b1000 : (i < 22) ? 4'b1100 :
                         (i == 22) ? 4'b1110 : 4'b0011)) begin
                miscompares++;
                $display("FAIL nto_ctl[%0d] got %b", i, ctl);
            end
            if (i == 23) begin
                vectors++;
                if ({rsp_err, rsp_timeout, rsp_rdata} !== {2'b00, 32'h2468_ACE0}) begin
                    miscompares++;
                    $display("FAIL nto_rsp got %h expected 0_2468ace0",
                             {rsp_err, rsp_timeout, rsp_rdata});
                end
            end
            cyc();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait_states();
        test_back_to_back();
        test_slave_error();
        test_reset_mid_transfer();
`ifdef APB_MASTER_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
